axis_video_pattern_gen: RTL and testbench
=========================================

Name: axis_video_pattern_gen

Overview:
- AXI4-Stream video source that generates RGB565 test frames. It is the transmitter end of the stream that feeds the greyscaler's slave port.
- Emits H_ACTIVE x V_ACTIVE pixels per frame, with TUSER as start-of-frame and TLAST as end-of-line, and obeys TREADY backpressure.
- Used in benches and on-chip as a camera-less frame source ahead of the processing chain.

Parameters:
- DATA_WIDTH, 16, pixel width. Only 16 (RGB565) is legal; elaboration fails on any other value.
- H_ACTIVE, 640, pixels per line. Must be a multiple of 8 and at least 8.
- V_ACTIVE, 480, lines per frame, at least 1.
- V_BLANK, 16, idle cycles inserted between frames. 0 is allowed.

Ports:
- clk  in  1  stream clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- pattern_sel  in  2  0 solid, 1 colour bars, 2 grey ramp, 3 checkerboard.
- solid_color  in  16  RGB565 value used by pattern 0.
- M_AXIS_TDATA  out  DATA_WIDTH  pixel.
- M_AXIS_TVALID  out  1  pixel valid.
- M_AXIS_TREADY  in  1  sink ready.
- M_AXIS_VIDEO_TLAST  out  1  last pixel of line.
- M_AXIS_VIDEO_TUSER  out  1  first pixel of frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_count  out  16  completed frames; wraps at 0xFFFF -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset s_axis_aresetn is asynchronous assert, active-low, with release synchronous to clk.
- Reset values: all outputs 0; x = y = 0; state IDLE; frame_count = 0.
- States:
  - IDLE: TVALID = 0. When enable = 1, latch pattern_sel and solid_color into frame registers, load pixel (0,0), go to STREAM. TVALID rises on the cycle after enable is first seen high, so latency is 1.
  - STREAM: outputs are registered. A handshake is TVALID & TREADY.
  - On each handshake the next pixel is loaded.
  - x increments, and wraps to 0 after H_ACTIVE-1 with y incrementing.
  - After the handshake at (H_ACTIVE-1, V_ACTIVE-1): frame_done pulses and frame_count increments on the next cycle. Next state is GAP if V_BLANK > 0, else the frame-start check below.
  - GAP: TVALID = 0. Count V_BLANK cycles, then do the frame-start check.
  - Frame-start check: if enable = 1, re-latch the pattern registers and load (0,0) in STREAM; otherwise go to IDLE.
- AXIS rules:
  - While TVALID = 1 and TREADY = 0, TDATA, TLAST and TUSER hold stable.
  - TVALID never drops without a handshake.
  - TVALID is not conditioned on TREADY.
  - Back-to-back handshakes run at one pixel per clock with no bubbles inside a frame.
- Sidebands:
  - TUSER = 1 only at (0,0).
  - TLAST = 1 only at x = H_ACTIVE-1.
  - With H_ACTIVE = 1 is illegal (minimum 8).
- enable deasserted mid-frame: the current frame completes in full, then the block returns to IDLE. Frames are never truncated.
- pattern_sel and solid_color changes mid-frame are ignored until the next frame start.
- Patterns, with (x, y) the current pixel:
  - 0: solid_color.
  - 1: eight bars, each H_ACTIVE/8 wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
    - Bar index comes from a bar counter and remainder counter, with no divider.
  - 2: grey ramp {x[7:3], x[7:2], x[7:3]}, which wraps every 256 pixels.
  - 3: (x[5] ^ y[5]) ? FFFF : 0000, i.e. 32x32 squares.
- Widths:
  - x is $clog2(H_ACTIVE) bits and y is $clog2(V_ACTIVE) bits, sized to at least 8 and 6 bits respectively for the pattern slices.
  - Pattern math uses the next-pixel coordinates, so TDATA is registered with no combinational path from TREADY to TDATA.
- Reset asserted mid-frame: immediate return to reset values; TVALID drops asynchronously.

Decomposition:
- Package video_pkg:
  - typedef rgb565_t (16-bit).
  - enum pattern_e {PAT_SOLID, PAT_BARS, PAT_RAMP, PAT_CHECK}.
  - localparam array BAR_COLORS[8].
  - enum gen_state_e {IDLE, STREAM, GAP}.
- Sub-module video_pattern_lut: purely combinational (pattern, x, y, bar_idx, solid) -> rgb565. This keeps the FSM and counters separate from the pixel mapping.

Test Plan:
- Reset, then enable = 1, pattern 0, solid_color = 0xF800, TREADY = 1, H_ACTIVE = 8, V_ACTIVE = 4:
  - TVALID rises 1 cycle after enable.
  - Exactly 32 beats, all 0xF800.
  - TUSER on beat 0 only; TLAST on beats 7, 15, 23, 31.
  - frame_done pulses once; frame_count = 1.
- Pattern 1, H_ACTIVE = 16:
  - Beat pairs per line: FFFF, FFFF, FFE0, FFE0, ..., 0000, 0000.
  - Identical on every line.
- Random TREADY toggling (50%) with pattern 2, H_ACTIVE = 640:
  - Protocol checker: TDATA, TLAST and TUSER are stable while stalled; TVALID never drops without a handshake.
  - Line data equals the ramp; value at x = 256 equals the value at x = 0.
- enable dropped at beat 5 of a 32-pixel frame:
  - All 32 beats are still sent.
  - After the V_BLANK gap, state is IDLE and TVALID = 0.
- pattern_sel changed 3 -> 0 mid-frame with enable held:
  - The current frame stays checkerboard.
  - The next frame starts with TUSER = 1 and is solid.
  - Exactly V_BLANK = 16 TVALID-low cycles between the frames.
- s_axis_aresetn pulsed low mid-line:
  - TVALID = 0 asynchronously; frame_count = 0.
  - After release with enable = 1, the stream restarts at (0,0) with TUSER = 1.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern source.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package video_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } gen_state_e;

  // Classic SMPTE-like bar order, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam rgb565_t BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Used to give counters a minimum width so the fixed pattern slices exist.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/video_pattern_lut.sv
// Maps a pattern selection and pixel coordinate to an RGB565 value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module video_pattern_lut
  import video_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  pattern_e        pattern,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  input  logic [2:0]      bar_idx,
  input  rgb565_t         solid,
  output rgb565_t         pixel
);

  // Only a few coordinate bits feed the patterns; the rest are intentionally ignored.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x, y};

  // Pixel mapping for the four test patterns.
  always_comb begin
    pixel = solid;
    case (pattern)
      PAT_SOLID: pixel = solid;
      PAT_BARS:  pixel = BAR_COLORS[bar_idx];
      PAT_RAMP:  pixel = {x[7:3], x[7:2], x[7:3]};
      PAT_CHECK: pixel = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      default:   pixel = solid;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream RGB565 test-frame source (TUSER = start of frame, TLAST = end of line).
// Latency: TVALID rises one cycle after enable is seen; one pixel per clock when ready.
// Backpressure: holds TDATA/TLAST/TUSER stable while TREADY is low; frames never truncate.
module axis_video_pattern_gen
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  s_axis_aresetn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [15:0]           solid_color,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_VIDEO_TLAST,
  output logic                  M_AXIS_VIDEO_TUSER,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int XW    = max2($clog2(H_ACTIVE), 8);
  localparam int YW    = max2($clog2(V_ACTIVE), 6);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int RW    = max2($clog2(BAR_W), 1);
  localparam int GW    = max2($clog2(V_BLANK), 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [RW-1:0] R_LAST = RW'(BAR_W - 1);
  localparam logic [GW-1:0] G_LAST = GW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("axis_video_pattern_gen: DATA_WIDTH must be 16 (RGB565)");
  end
  if ((H_ACTIVE < 8) || ((H_ACTIVE % 8) != 0)) begin : g_bad_h
    $error("axis_video_pattern_gen: H_ACTIVE must be a multiple of 8, at least 8");
  end
  if (V_ACTIVE < 1) begin : g_bad_v
    $error("axis_video_pattern_gen: V_ACTIVE must be at least 1");
  end

  gen_state_e    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    bar_idx;
  logic [RW-1:0] bar_rem;
  pattern_e      pat_q;
  rgb565_t       solid_q;
  logic [GW-1:0] gap_cnt;

  logic          handshake;
  logic          last_pix;
  logic          starting;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [2:0]    nbar;
  logic [RW-1:0] nrem;

  pattern_e      lut_pat;
  rgb565_t       lut_solid;
  logic [XW-1:0] lut_x;
  logic [YW-1:0] lut_y;
  logic [2:0]    lut_bar;
  rgb565_t       lut_pix;

  assign handshake = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_pix  = (x == X_LAST) && (y == Y_LAST);

  // Next raster position; bar index advances via a remainder counter instead of x / BAR_W.
  always_comb begin
    nx   = x + 1'b1;
    ny   = y;
    nbar = bar_idx;
    nrem = bar_rem + 1'b1;
    if (x == X_LAST) begin
      nx   = '0;
      ny   = (y == Y_LAST) ? '0 : y + 1'b1;
      nbar = '0;
      nrem = '0;
    end else if (bar_rem == R_LAST) begin
      nrem = '0;
      nbar = bar_idx + 3'd1;
    end
  end

  // A new frame starts from IDLE, at the end of the blanking gap, or back-to-back without a gap.
  always_comb begin
    starting = 1'b0;
    case (state)
      IDLE:    starting = enable;
      STREAM:  starting = enable && handshake && last_pix && (V_BLANK == 0);
      GAP:     starting = enable && (gap_cnt == G_LAST);
      default: starting = 1'b0;
    endcase
  end

  // At a frame start the LUT sees the live inputs at (0,0); otherwise the latched frame settings.
  always_comb begin
    lut_pat   = starting ? pattern_e'(pattern_sel) : pat_q;
    lut_solid = starting ? solid_color : solid_q;
    lut_x     = starting ? '0 : nx;
    lut_y     = starting ? '0 : ny;
    lut_bar   = starting ? '0 : nbar;
  end

  video_pattern_lut #(
    .XW (XW),
    .YW (YW)
  ) u_lut (
    .pattern (lut_pat),
    .x       (lut_x),
    .y       (lut_y),
    .bar_idx (lut_bar),
    .solid   (lut_solid),
    .pixel   (lut_pix)
  );

  // Frame FSM with raster counters and registered stream outputs.
  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state              <= IDLE;
      x                  <= '0;
      y                  <= '0;
      bar_idx            <= '0;
      bar_rem            <= '0;
      pat_q              <= PAT_SOLID;
      solid_q            <= '0;
      gap_cnt            <= '0;
      M_AXIS_TDATA       <= '0;
      M_AXIS_TVALID      <= 1'b0;
      M_AXIS_VIDEO_TLAST <= 1'b0;
      M_AXIS_VIDEO_TUSER <= 1'b0;
      frame_done         <= 1'b0;
      frame_count        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (starting) begin
        state              <= STREAM;
        pat_q              <= pattern_e'(pattern_sel);
        solid_q            <= solid_color;
        x                  <= '0;
        y                  <= '0;
        bar_idx            <= '0;
        bar_rem            <= '0;
        gap_cnt            <= '0;
        M_AXIS_TDATA       <= lut_pix;
        M_AXIS_TVALID      <= 1'b1;
        M_AXIS_VIDEO_TUSER <= 1'b1;
        M_AXIS_VIDEO_TLAST <= 1'b0;
      end
      case (state)
        STREAM: begin
          if (handshake) begin
            if (last_pix) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (!starting) begin
                M_AXIS_TVALID      <= 1'b0;
                M_AXIS_VIDEO_TUSER <= 1'b0;
                M_AXIS_VIDEO_TLAST <= 1'b0;
                gap_cnt            <= '0;
                state              <= (V_BLANK > 0) ? GAP : IDLE;
              end
            end else begin
              x                  <= nx;
              y                  <= ny;
              bar_idx            <= nbar;
              bar_rem            <= nrem;
              M_AXIS_TDATA       <= lut_pix;
              M_AXIS_VIDEO_TLAST <= (nx == X_LAST);
              M_AXIS_VIDEO_TUSER <= 1'b0;
            end
          end
        end
        GAP: begin
          if (!starting) begin
            if (gap_cnt == G_LAST) state <= IDLE;
            else                   gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench: a 64x2 instance with a 16-cycle gap and a 640x1 instance without a gap.
module tb_axis_video_pattern_gen;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        tready = 1'b1;
  logic [15:0] tdata;
  logic        tvalid, tlast, tuser, frame_done;
  logic [15:0] frame_count;

  logic        en_w = 1'b0;
  logic        rdy_w = 1'b1;
  logic [1:0]  psel_w = 2'd2;
  logic [15:0] solid_w = 16'h0000;
  logic [15:0] dat_w;
  logic        vld_w, last_w, user_w, fd_w;
  logic [15:0] fc_w;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int fdw_cnt = 0;
  int nb = 0;

  logic [15:0] bd [128];
  logic        bl [128];
  logic        bu [128];
  logic [15:0] bw [640];
  logic        bwl [640];
  logic        bwu [640];
  logic [15:0] bar_exp [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  axis_video_pattern_gen #(.DATA_WIDTH(16), .H_ACTIVE(64), .V_ACTIVE(2), .V_BLANK(16)) dut (
    .clk(clk), .s_axis_aresetn(arstn), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready), .M_AXIS_VIDEO_TLAST(tlast), .M_AXIS_VIDEO_TUSER(tuser),
    .frame_done(frame_done), .frame_count(frame_count));

  axis_video_pattern_gen #(.DATA_WIDTH(16), .H_ACTIVE(640), .V_ACTIVE(1), .V_BLANK(0)) dut_w (
    .clk(clk), .s_axis_aresetn(arstn), .enable(en_w), .pattern_sel(psel_w),
    .solid_color(solid_w), .M_AXIS_TDATA(dat_w), .M_AXIS_TVALID(vld_w),
    .M_AXIS_TREADY(rdy_w), .M_AXIS_VIDEO_TLAST(last_w), .M_AXIS_VIDEO_TUSER(user_w),
    .frame_done(fd_w), .frame_count(fc_w));

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (fd_w) fdw_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ramp(input logic [9:0] xv);
    return {xv[7:3], xv[7:2], xv[7:3]};
  endfunction

  // Collects n beats from the main instance, checking stall stability on the way.
  task automatic collect(input int n, input int drop_at, input int chg_at, input bit rnd, input int max_cyc);
    int          cyc = 0;
    bit          pstall = 1'b0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    logic        pu = 1'b0;
    nb = 0;
    while (nb < n && cyc < max_cyc) begin
      if (pstall) begin
        check("stall_tvalid", 32'(tvalid), 1);
        check("stall_tdata", 32'(tdata), 32'(pd));
        check("stall_tlast", 32'(tlast), 32'(pl));
        check("stall_tuser", 32'(tuser), 32'(pu));
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pstall = tvalid && !tready;
      pd = tdata;
      pl = tlast;
      pu = tuser;
      if (tvalid && tready) begin
        bd[nb] = tdata;
        bl[nb] = tlast;
        bu[nb] = tuser;
        if (nb == drop_at) enable = 1'b0;
        if (nb == chg_at) begin
          pattern_sel = 2'd0;
          solid_color = 16'h1234;
        end
        nb++;
      end
      tick();
      cyc++;
    end
    tready = 1'b1;
    check("beat_count", nb, n);
  endtask

  task automatic check_sidebands();
    for (int i = 0; i < 128; i++) begin
      check($sformatf("tuser[%0d]", i), 32'(bu[i]), (i == 0) ? 1 : 0);
      check($sformatf("tlast[%0d]", i), 32'(bl[i]), ((i % 64) == 63) ? 1 : 0);
    end
  endtask

  initial begin
    int lows;
    int hi_cnt;
    int cyc;
    bit pstall;
    logic [15:0] pd;
    logic pl, pu;

    // Reset values
    tick(); tick();
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    arstn = 1'b1;
    tick();

    // Solid frame, enable dropped at beat 5
    enable = 1'b1; pattern_sel = 2'd0; solid_color = 16'hF800;
    check("pre_tvalid", 32'(tvalid), 0);
    tick();
    check("latency_tvalid", 32'(tvalid), 1);
    check("first_tuser", 32'(tuser), 1);
    collect(128, 5, -1, 1'b0, 400);
    check("frame_done_pulse", 32'(frame_done), 1);
    check("frame_count_1", 32'(frame_count), 1);
    check("gap_tvalid", 32'(tvalid), 0);
    for (int i = 0; i < 128; i++) check($sformatf("solid[%0d]", i), 32'(bd[i]), 32'h0000F800);
    check_sidebands();
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid) hi_cnt++;
      tick();
    end
    check("no_restart_cycles", hi_cnt, 0);
    check("idle_state", 32'(dut.state), 0);
    check("frame_done_count", fd_cnt, 1);

    // Colour bars, eight beats per bar on a 64-pixel line
    enable = 1'b1; pattern_sel = 2'd1;
    tick();
    collect(128, 0, -1, 1'b0, 400);
    for (int i = 0; i < 128; i++) check($sformatf("bars[%0d]", i), 32'(bd[i]), 32'(bar_exp[(i % 64) / 8]));
    check_sidebands();
    for (int i = 0; i < 20; i++) tick();

    // Grey ramp with random backpressure
    enable = 1'b1; pattern_sel = 2'd2;
    tick();
    collect(128, 0, -1, 1'b1, 2000);
    for (int i = 0; i < 128; i++) check($sformatf("ramp[%0d]", i), 32'(bd[i]), 32'(ramp(10'(i % 64))));
    check("ramp_x4", 32'(bd[4]), 32'h0020);
    check("ramp_x8", 32'(bd[8]), 32'h0841);
    check_sidebands();
    for (int i = 0; i < 20; i++) tick();
    check("frame_count_3", 32'(frame_count), 3);

    // Wide instance: 640-pixel ramp line, random backpressure, no gap
    en_w = 1'b1;
    tick();
    nb = 0; cyc = 0; pstall = 1'b0; pd = '0; pl = 1'b0; pu = 1'b0;
    while (nb < 640 && cyc < 4000) begin
      if (pstall) begin
        check("w_stall_tvalid", 32'(vld_w), 1);
        check("w_stall_tdata", 32'(dat_w), 32'(pd));
        check("w_stall_tlast", 32'(last_w), 32'(pl));
        check("w_stall_tuser", 32'(user_w), 32'(pu));
      end
      rdy_w = 1'($urandom_range(0, 1));
      pstall = vld_w && !rdy_w;
      pd = dat_w; pl = last_w; pu = user_w;
      if (vld_w && rdy_w) begin
        bw[nb] = dat_w; bwl[nb] = last_w; bwu[nb] = user_w;
        en_w = 1'b0;
        nb++;
      end
      tick();
      cyc++;
    end
    rdy_w = 1'b1;
    check("w_beat_count", nb, 640);
    for (int i = 0; i < 640; i++) check($sformatf("w_ramp[%0d]", i), 32'(bw[i]), 32'(ramp(10'(i))));
    check("w_ramp_x255", 32'(bw[255]), 32'hFFFF);
    check("w_ramp_wrap", 32'(bw[256]), 32'(bw[0]));
    check("w_tuser0", 32'(bwu[0]), 1);
    check("w_tlast639", 32'(bwl[639]), 1);
    check("w_tlast638", 32'(bwl[638]), 0);
    tick(); tick();
    check("w_frame_count", 32'(fc_w), 1);
    check("w_frame_done", fdw_cnt, 1);
    check("w_idle_tvalid", 32'(vld_w), 0);

    // Checkerboard frame, pattern changed to solid mid-frame with enable held
    enable = 1'b1; pattern_sel = 2'd3; solid_color = 16'h5555;
    tick();
    collect(128, -1, 10, 1'b0, 400);
    for (int i = 0; i < 128; i++) check($sformatf("check[%0d]", i), 32'(bd[i]), ((i % 64) >= 32) ? 32'hFFFF : 32'h0);
    check_sidebands();
    lows = 0;
    while (!tvalid && lows < 100) begin
      tick();
      lows++;
    end
    check("gap_cycles", lows, 16);
    check("next_tuser", 32'(tuser), 1);
    check("next_tdata", 32'(tdata), 32'h1234);
    collect(128, 0, -1, 1'b0, 400);
    for (int i = 0; i < 128; i++) check($sformatf("solid2[%0d]", i), 32'(bd[i]), 32'h1234);
    for (int i = 0; i < 20; i++) tick();
    check("frame_count_5", 32'(frame_count), 5);
    check("frame_done_total", fd_cnt, 5);

    // Reset pulse mid-line
    enable = 1'b1; pattern_sel = 2'd0; solid_color = 16'hABCD;
    tick();
    collect(20, -1, -1, 1'b0, 100);
    check("pre_rst_tvalid", 32'(tvalid), 1);
    arstn = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(tvalid), 0);
    check("async_rst_count", 32'(frame_count), 0);
    check("async_rst_tuser", 32'(tuser), 0);
    #2;
    arstn = 1'b1;
    tick();
    check("restart_tvalid", 32'(tvalid), 1);
    check("restart_tuser", 32'(tuser), 1);
    check("restart_tdata", 32'(tdata), 32'hABCD);
    check("restart_tlast", 32'(tlast), 0);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
